// File: rtl/add_acc_if.sv
// Handshake bundle for add_acc_pipe: producer-side operands in, consumer-side result out.
// The master side is the bench or producer; the slave side is the adder pipeline.
interface add_acc_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 mode;
  logic                 acc_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] sum;
  logic                 ovf;

  modport master (
    output in_valid, a, b, mode, acc_clr, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport slave (
    input  in_valid, a, b, mode, acc_clr, out_ready,
    output in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/add_acc_pipe.sv
// Pipelined add / accumulate datapath with valid/ready on both sides.
// The result is formed at accept time, then carried through LATENCY stages that stall together.
module add_acc_pipe #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int LATENCY   = 2,
  parameter int SAT       = 0
) (
  input logic   clk,
  input logic   rst,
  add_acc_if.slave bus
);
  typedef struct packed {
    logic [ACC_WIDTH-1:0] sum;
    logic                 ovf;
  } res_t;

  logic                    adv;
  logic                    accept;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    base;
  logic [ACC_WIDTH-1:0]    ab_ext;
  logic [ACC_WIDTH:0]      acc_t;
  res_t                    res_in;
  logic [LATENCY:1]        vld_pipe;
  res_t [LATENCY:1]        res_pipe;

  // One enable for the whole pipe: it moves whenever the output slot is free or draining.
  assign adv          = !vld_pipe[LATENCY] || bus.out_ready;
  assign bus.in_ready = adv && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  assign base   = bus.acc_clr ? '0 : acc;
  assign ab_ext = {{(ACC_WIDTH-WIDTH){1'b0}}, bus.a} + {{(ACC_WIDTH-WIDTH){1'b0}}, bus.b};
  assign acc_t  = {1'b0, base} + {1'b0, ab_ext};

  always_comb begin
    res_in = '0;
    if (bus.mode) begin
      res_in.ovf = acc_t[ACC_WIDTH];
      if (acc_t[ACC_WIDTH] && (SAT != 0))
        res_in.sum = '1;
      else
        res_in.sum = acc_t[ACC_WIDTH-1:0];
    end else begin
      res_in.sum = ab_ext;
    end
  end

  // Accumulator only moves at accept, so output backpressure can never double-count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (accept && bus.mode)
      acc <= res_in.sum;
    else if (bus.acc_clr)
      acc <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      res_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= accept;
      res_pipe[1] <= res_in;
      for (int s = 2; s <= LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        res_pipe[s] <= res_pipe[s-1];
      end
    end
  end

  assign bus.out_valid = vld_pipe[LATENCY];
  assign bus.sum       = res_pipe[LATENCY].sum;
  assign bus.ovf       = res_pipe[LATENCY].ovf;
endmodule

// File: tb/tb_add_acc_pipe.sv
// Bench for add_acc_pipe: a wrap and a saturating instance share one stimulus stream,
// each scored against a transaction-level model of the add/accumulate rules.
module tb_add_acc_pipe;
  localparam int W    = 4;
  localparam int AW   = 8;
  localparam int L    = 2;
  localparam int MAXV = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_acc_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus0 ();
  add_acc_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.a         = bus0.a;
  assign bus1.b         = bus0.b;
  assign bus1.mode      = bus0.mode;
  assign bus1.acc_clr   = bus0.acc_clr;
  assign bus1.out_ready = bus0.out_ready;

  add_acc_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .LATENCY(L), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  add_acc_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .LATENCY(L), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  logic          ov [2];
  logic          ir [2];
  logic          of [2];
  logic [AW-1:0] sm [2];
  assign ov[0] = bus0.out_valid; assign ov[1] = bus1.out_valid;
  assign ir[0] = bus0.in_ready;  assign ir[1] = bus1.in_ready;
  assign of[0] = bus0.ovf;       assign of[1] = bus1.ovf;
  assign sm[0] = bus0.sum;       assign sm[1] = bus1.sum;

  // Expected result plus the cycle it was accepted and the stall count at that time;
  // every stall cycle after acceptance delays its appearance by one.
  typedef struct {
    int sum;
    int ovf;
    int cyc;
    int st0;
  } exp_t;

  exp_t q [2][$];
  int   macc [2];
  int   stalls [2];
  int   cyc;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      macc[d] = 0;
    end
  endtask

  // Inputs are already driven for this cycle; check outputs, advance the model, step one clock.
  task automatic cycle();
    #1;
    for (int d = 0; d < 2; d++) begin
      bit expv;
      bit accv;
      int r, o, t;
      expv = 1'b0;
      if (q[d].size() > 0)
        expv = (cyc >= q[d][0].cyc + L + (stalls[d] - q[d][0].st0));
      chk($sformatf("out_valid[%0d]", d), ov[d], expv);
      chk($sformatf("in_ready[%0d]", d), ir[d], !expv || bus0.out_ready);
      if (expv) begin
        chk($sformatf("sum[%0d]", d), sm[d], q[d][0].sum);
        chk($sformatf("ovf[%0d]", d), of[d], q[d][0].ovf);
      end
      if (expv && !bus0.out_ready) stalls[d]++;
      if (expv && bus0.out_ready) void'(q[d].pop_front());
      accv = bus0.in_valid && (!expv || bus0.out_ready);
      if (accv) begin
        if (bus0.mode) begin
          t = (bus0.acc_clr ? 0 : macc[d]) + int'(bus0.a) + int'(bus0.b);
          if (t > MAXV) begin
            o = 1;
            r = (d == 1) ? MAXV : t - (MAXV + 1);
          end else begin
            o = 0;
            r = t;
          end
          macc[d] = r;
        end else begin
          r = int'(bus0.a) + int'(bus0.b);
          o = 0;
          if (bus0.acc_clr) macc[d] = 0;
        end
        q[d].push_back('{r, o, cyc, stalls[d]});
      end else if (bus0.acc_clr) begin
        macc[d] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int av, input int bv, input bit m, input bit c);
    bus0.in_valid = 1'b1;
    bus0.a        = W'(av);
    bus0.b        = W'(bv);
    bus0.mode     = m;
    bus0.acc_clr  = c;
    cycle();
  endtask

  task automatic idle(input int n);
    bus0.in_valid = 1'b0;
    bus0.acc_clr  = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    stalls[0] = 0; stalls[1] = 0;
    reset_model();
    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0;
    bus0.mode = 1'b0; bus0.acc_clr = 1'b0; bus0.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", ov[d], 1'b0);
      chk("rst_in_ready", ir[d], 1'b0);
      chk("rst_sum", sm[d], '0);
      chk("rst_ovf", of[d], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // plain adds, then a back-to-back stream
    send(1, 5, 0, 0); idle(2);
    send(15, 15, 0, 0); idle(3);
    for (int i = 3; i <= 6; i++) send(i, 5, 0, 0);
    idle(3);

    // fill, hold off the consumer for 3 cycles while a producer keeps offering
    send(1, 2, 0, 0); send(3, 4, 0, 0); send(5, 6, 0, 0);
    bus0.out_ready = 1'b0;
    bus0.a = 4'd7; bus0.b = 4'd7;
    repeat (3) cycle();
    bus0.out_ready = 1'b1;
    idle(5);

    // accumulate to overflow: wrap gives 14, saturate pins at 255
    bus0.in_valid = 1'b0; bus0.acc_clr = 1'b1; cycle();
    bus0.acc_clr = 1'b0;
    repeat (9) send(15, 15, 1, 0);
    send(1, 1, 1, 0);
    idle(3);

    // clear coincident with an accumulate
    send(15, 15, 1, 1); send(15, 15, 1, 0); send(15, 15, 1, 0); send(5, 5, 1, 0);
    send(2, 3, 1, 1); send(1, 0, 1, 0);
    send(4, 4, 0, 1); send(2, 2, 1, 0);
    idle(3);

    // asynchronous reset between edges with results in flight
    send(1, 2, 0, 0); send(3, 4, 1, 0);
    bus0.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_out_valid", ov[d], 1'b0);
      chk("async_rst_in_ready", ir[d], 1'b0);
      chk("async_rst_sum", sm[d], '0);
    end
    reset_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(1, 1, 1, 0);
    idle(3);

    // randomized traffic with backpressure and occasional clears
    repeat (1500) begin
      bus0.in_valid  = ($urandom_range(0, 3) != 0);
      bus0.a         = W'($urandom_range(0, 15));
      bus0.b         = W'($urandom_range(0, 15));
      bus0.mode      = ($urandom_range(0, 2) != 0);
      bus0.acc_clr   = ($urandom_range(0, 24) == 0);
      bus0.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus0.out_ready = 1'b1;
    idle(L + 4);
    chk("drain_q0", q[0].size(), 0);
    chk("drain_q1", q[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
